// File: rtl/bit_serializer.sv
// Word-to-bit serializer feeding the sequence detector: valid/ready word input, one bit per clock on x.
// Optional macro SER_DOUBLE_BUF_EN adds a one-entry holding register so that back-to-back words stream with no gap.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             abort,
   output logic             x,
   output logic             x_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   if (WIDTH < 2) begin : g_width_check
      $error("bit_serializer: WIDTH must be at least 2");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic               x_q, x_d;
   logic               x_valid_q, x_valid_d;
   logic               word_done_q, word_done_d;
   logic               busy_q, busy_d;
`ifdef SER_DOUBLE_BUF_EN
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
`endif

   logic               accept;
   logic               load;
   logic [WIDTH-1:0]   load_word;

   // sr always holds the bits not yet placed on x, so the next bit is at the send end.
   function automatic logic send_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

`ifdef SER_DOUBLE_BUF_EN
   assign in_ready = !hold_full_q && !abort;
`else
   assign in_ready = (state_q == IDLE) && !abort;
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      load        = 1'b0;
      load_word   = '0;
`ifdef SER_DOUBLE_BUF_EN
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`endif

      if (abort) begin
         state_d     = IDLE;
         cnt_d       = '0;
         sr_d        = '0;
`ifdef SER_DOUBLE_BUF_EN
         hold_d      = '0;
         hold_full_d = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  load      = 1'b1;
                  load_word = in_data;
               end
            end
            SHIFT: begin
               if (cnt_q > CNT_W'(1)) begin
                  cnt_d = cnt_q - CNT_W'(1);
                  sr_d  = drop_bit(sr_q);
`ifdef SER_DOUBLE_BUF_EN
                  if (accept) begin
                     hold_d      = in_data;
                     hold_full_d = 1'b1;
                  end
`endif
               end else begin
`ifdef SER_DOUBLE_BUF_EN
                  // Last bit: chain the held word (or one arriving now) with no gap.
                  if (hold_full_q) begin
                     load        = 1'b1;
                     load_word   = hold_q;
                     hold_d      = accept ? in_data : '0;
                     hold_full_d = accept;
                  end else if (accept) begin
                     load      = 1'b1;
                     load_word = in_data;
                  end else begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     sr_d    = '0;
                  end
`else
                  state_d = IDLE;
                  cnt_d   = '0;
                  sr_d    = '0;
`endif
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               sr_d    = '0;
            end
         endcase
      end

      if (load) begin
         state_d = SHIFT;
         cnt_d   = CNT_W'(WIDTH);
         sr_d    = drop_bit(load_word);
      end

      x_valid_d   = (state_d == SHIFT);
      busy_d      = (state_d == SHIFT);
      word_done_d = (state_d == SHIFT) && (cnt_d == CNT_W'(1));
      if (state_d != SHIFT) begin
         x_d = IDLE_BIT;
      end else if (load) begin
         x_d = send_bit(load_word);
      end else begin
         x_d = send_bit(sr_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         x_q         <= IDLE_BIT;
         x_valid_q   <= 1'b0;
         word_done_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SER_DOUBLE_BUF_EN
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         x_q         <= x_d;
         x_valid_q   <= x_valid_d;
         word_done_q <= word_done_d;
         busy_q      <= busy_d;
`ifdef SER_DOUBLE_BUF_EN
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`endif
      end
   end

   assign x         = x_q;
   assign x_valid   = x_valid_q;
   assign word_done = word_done_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_bit_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       abort;
   logic [1:0] rdy_w, x_w, xv_w, wd_w, busy_w;

   int checks;
   int errors;

   // Expected bit stream per instance: {last_bit_of_word, bit_value}
   logic [1:0] q0[$];
   logic [1:0] q1[$];
   logic [1:0] prev_done;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_w[0]),
      .abort(abort), .x(x_w[0]), .x_valid(xv_w[0]), .word_done(wd_w[0]), .busy(busy_w[0])
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_w[1]),
      .abort(abort), .x(x_w[1]), .x_valid(xv_w[1]), .word_done(wd_w[1]), .busy(busy_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, exp);
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         q0.push_back({i == 7, w[7-i]});
         q1.push_back({i == 7, w[i]});
      end
   endtask

   task automatic flush();
      q0.delete();
      q1.delete();
   endtask

   // Present a word and wait for the accepting edge; in_valid is left high on return.
   task automatic send(input logic [7:0] w);
      logic r;
      int   n;
      n        = 0;
      in_data  = w;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         r = rdy_w[0];
         @(posedge clk);
         if (r) break;
         n++;
         if (n > 100) begin
            chk("accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      if (r) push_word(w);
      #1;
   endtask

   task automatic pulse_abort();
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk);
      flush();
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic mon(input int k);
      logic [1:0] e;
      int         sz;
      int         lasts;
      logic       exp_rdy;
      sz    = (k == 0) ? q0.size() : q1.size();
      lasts = 0;
      for (int i = 0; i < sz; i++) begin
         e = (k == 0) ? q0[i] : q1[i];
         lasts += int'(e[1]);
      end
`ifdef SER_DOUBLE_BUF_EN
      exp_rdy = (lasts < 2) && !abort;
`else
      exp_rdy = (sz == 0) && !abort;
      if (prev_done[k]) chk($sformatf("gap_after_word%0d", k), 32'(xv_w[k]), 32'd0);
`endif
      chk($sformatf("x_valid_vs_pending%0d", k), 32'(xv_w[k]), 32'(sz != 0));
      chk($sformatf("in_ready%0d", k), 32'(rdy_w[k]), 32'(exp_rdy));
      chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(xv_w[k]));
      if (xv_w[k] === 1'b1 && sz != 0) begin
         e = (k == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("x_bit%0d", k), 32'(x_w[k]), 32'(e[0]));
         chk($sformatf("word_done%0d", k), 32'(wd_w[k]), 32'(e[1]));
      end else begin
         chk($sformatf("x_idle%0d", k), 32'(x_w[k]), 32'd0);
         chk($sformatf("word_done_idle%0d", k), 32'(wd_w[k]), 32'd0);
      end
      prev_done[k] = wd_w[k];
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic chk_idle(input string nm, input int k);
      chk({nm, "_x"}, 32'(x_w[k]), 32'd0);
      chk({nm, "_xv"}, 32'(xv_w[k]), 32'd0);
      chk({nm, "_wd"}, 32'(wd_w[k]), 32'd0);
      chk({nm, "_busy"}, 32'(busy_w[k]), 32'd0);
      chk({nm, "_rdy"}, 32'(rdy_w[k]), 32'd1);
   endtask

   initial begin
      logic [7:0] e;
      logic [31:0] w;
      int g;
      checks    = 0;
      errors    = 0;
      prev_done = '0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      abort     = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk_idle("reset_msb", 0);
      chk_idle("reset_lsb", 1);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // C5, MSB first: exact latency and word_done position
      send(8'hC5);
      in_valid = 1'b0;
      e = 8'hC5;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("c5_x", 32'(x_w[0]), 32'(e[7-i]));
         chk("c5_xv", 32'(xv_w[0]), 32'd1);
         chk("c5_wd", 32'(wd_w[0]), 32'(i == 7));
         chk("c5_rdy", 32'(rdy_w[0]), 32'd0);
      end
      @(negedge clk);
      chk("c5_after_xv", 32'(xv_w[0]), 32'd0);
      @(posedge clk);
      #1;

      // streamed pair with in_valid held high
      send(8'hA5);
      send(8'h3C);
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // 06, LSB first
      send(8'h06);
      in_valid = 1'b0;
      e = 8'b0110_0000;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("06_x", 32'(x_w[1]), 32'(e[7-i]));
         chk("06_wd", 32'(wd_w[1]), 32'(i == 7));
      end
      @(posedge clk);
      #1;

      // abort during the third bit of FF (with a second word held when buffered)
      send(8'hFF);
`ifdef SER_DOUBLE_BUF_EN
      send(8'h81);
      in_valid = 1'b0;
`else
      in_valid = 1'b0;
      @(posedge clk);
      #1;
`endif
      @(posedge clk);
      #1;
      pulse_abort();
      @(negedge clk);
      chk_idle("abort_msb", 0);
      chk_idle("abort_lsb", 1);
      repeat (12) @(posedge clk);
      #1;

      // async reset after four bits of F0
      send(8'hF0);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      flush();
      #1;
      chk_idle("async_rst_msb", 0);
      chk_idle("async_rst_lsb", 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(8'h0F);
      in_valid = 1'b0;
      e = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("0f_x", 32'(x_w[0]), 32'(e[7-i]));
      end
      @(posedge clk);
      #1;

      // random words, gaps and aborts
      for (int n = 0; n < 40; n++) begin
         w = $urandom;
         send(w[7:0]);
         g = $urandom_range(0, 3);
         if (g != 0) begin
            in_valid = 1'b0;
            for (int j = 0; j < g; j++) begin
               @(posedge clk);
               #1;
            end
            if ($urandom_range(0, 7) == 0) pulse_abort();
         end
      end
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("drain_msb", 32'(q0.size()), 32'd0);
      chk("drain_lsb", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
